spi_master: RTL and testbench

Single-word SPI master that consumes the command produced by the UART-to-SPI control stage: `enable` strobe, `clk_div`, `addr` (chip-select index) and `tx_data`. It returns `busy`, which throttles that control stage. The block performs one 16-bit, MSB-first, SPI mode 0 transfer per accepted strobe. It drives SCLK, MOSI and one-hot active-low chip selects to the MEMS sensor, and returns the MISO word with a one-cycle valid pulse.

---
 rtl/spi_master_if.sv | 21 ++
 rtl/spi_master.sv | 176 +++++++++++++++++
 tb/tb_spi_master.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Command/response bundle between the UART-to-SPI control stage and the SPI master.
// The control stage owns the master modport; spi_master uses the slave modport.
interface spi_master_if;
  logic        enable;
  logic [31:0] clk_div;
  logic [31:0] addr;
  logic [15:0] tx_data;
  logic        busy;
  logic [15:0] rx_data;
  logic        rx_valid;

  modport master (
    output enable, clk_div, addr, tx_data,
    input  busy, rx_data, rx_valid
  );

  modport slave (
    input  enable, clk_div, addr, tx_data,
    output busy, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_master.sv
// Single-word SPI mode 0 master: one 16-bit MSB-first transfer per accepted strobe,
// one-hot active-low chip select, received word returned with a one-cycle valid pulse.
module spi_master #(
  parameter int CS_NUM = 4,
  parameter int DIV_W  = 16
) (
  input  logic              clk_150MHz_i,
  input  logic              reset,
  spi_master_if.slave       cmd,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [CS_NUM-1:0] cs_n
);

  localparam logic [31:0]      DIV_MAX32 = 32'((64'd1 << DIV_W) - 64'd1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO  = DIV_W'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [DIV_W-1:0]   div_r, cnt_r, div_s;
  logic [4:0]         edge_r;
  logic [15:0]        tx_shift_r, rx_shift_r;
  logic               miso_meta_r, miso_sync_r;
  logic               cnt_zero_s, last_edge_s;
  logic               busy_r, rx_valid_r, sclk_r, mosi_r;
  logic [15:0]        rx_data_r;
  logic [CS_NUM-1:0]  cs_n_r;

  // Out-of-range indices select nothing, leaving every line deasserted.
  function automatic logic [CS_NUM-1:0] cs_decode(input logic [31:0] a);
    logic [CS_NUM-1:0] v;
    v = {CS_NUM{1'b1}};
    for (int i = 0; i < CS_NUM; i++) begin
      if (a == 32'(i)) begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  assign cmd.busy     = busy_r;
  assign cmd.rx_data  = rx_data_r;
  assign cmd.rx_valid = rx_valid_r;
  assign sclk         = sclk_r;
  assign mosi         = mosi_r;
  assign cs_n         = cs_n_r;

  assign cnt_zero_s  = (cnt_r == DIV_ZERO);
  assign last_edge_s = (edge_r == 5'd31);

  always_comb begin
    div_s = DIV_ONE;
    if (cmd.clk_div == 32'd0) begin
      div_s = DIV_ONE;
    end else if (cmd.clk_div > DIV_MAX32) begin
      div_s = DIV_MAX32[DIV_W-1:0];
    end else begin
      div_s = cmd.clk_div[DIV_W-1:0];
    end
  end

  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd.enable) state_s = SETUP;
        else            state_s = IDLE;
      end
      SETUP: begin
        if (cnt_zero_s) state_s = XFER;
        else            state_s = SETUP;
      end
      XFER: begin
        if (cnt_zero_s && last_edge_s) state_s = HOLD;
        else                           state_s = XFER;
      end
      HOLD: begin
        if (cnt_zero_s) state_s = IDLE;
        else            state_s = HOLD;
      end
      default: state_s = IDLE;
    endcase
  end

  always_ff @(posedge clk_150MHz_i) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  always_ff @(posedge clk_150MHz_i) begin
    if (reset) begin
      miso_meta_r <= 1'b0;
      miso_sync_r <= 1'b0;
    end else begin
      miso_meta_r <= miso;
      miso_sync_r <= miso_meta_r;
    end
  end

  // Datapath and registered outputs, advanced by the same state the FSM decodes.
  always_ff @(posedge clk_150MHz_i) begin
    if (reset) begin
      div_r      <= DIV_ONE;
      cnt_r      <= DIV_ZERO;
      edge_r     <= 5'd0;
      tx_shift_r <= 16'h0000;
      rx_shift_r <= 16'h0000;
      busy_r     <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_data_r  <= 16'h0000;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      cs_n_r     <= {CS_NUM{1'b1}};
    end else begin
      rx_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd.enable) begin
            div_r      <= div_s;
            cnt_r      <= div_s - DIV_ONE;
            edge_r     <= 5'd0;
            tx_shift_r <= cmd.tx_data;
            rx_shift_r <= 16'h0000;
            busy_r     <= 1'b1;
            sclk_r     <= 1'b0;
            mosi_r     <= cmd.tx_data[15];
            cs_n_r     <= cs_decode(cmd.addr);
          end
        end
        SETUP: begin
          if (cnt_zero_s) cnt_r <= div_r - DIV_ONE;
          else            cnt_r <= cnt_r - DIV_ONE;
        end
        XFER: begin
          if (cnt_zero_s) begin
            cnt_r  <= div_r - DIV_ONE;
            sclk_r <= ~sclk_r;
            edge_r <= edge_r + 5'd1;
            if (!sclk_r) begin
              rx_shift_r <= {rx_shift_r[14:0], miso_sync_r};
            end else if (!last_edge_s) begin
              // The 16th falling edge leaves mosi on bit 0.
              tx_shift_r <= {tx_shift_r[14:0], 1'b0};
              mosi_r     <= tx_shift_r[14];
            end
          end else begin
            cnt_r <= cnt_r - DIV_ONE;
          end
        end
        HOLD: begin
          if (cnt_zero_s) begin
            busy_r     <= 1'b0;
            cs_n_r     <= {CS_NUM{1'b1}};
            mosi_r     <= 1'b0;
            rx_data_r  <= rx_shift_r;
            rx_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - DIV_ONE;
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a slave model returns a word per transfer and a
// monitor scoreboards MOSI bits, timing, chip select and the received word.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk, mosi, miso;
  logic [3:0] cs_n;

  spi_master_if bus ();

  // Narrow divider so the saturating case stays short (max div = 255).
  spi_master #(.CS_NUM(4), .DIV_W(8)) dut (
    .clk_150MHz_i (clk),
    .reset        (reset),
    .cmd          (bus),
    .sclk         (sclk),
    .mosi         (mosi),
    .miso         (miso),
    .cs_n         (cs_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] tx;
    logic [15:0] rx;
    bit          chk_rx;
    logic [3:0]  cs;
    int          len;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          rx_pulses = 0;
  logic [15:0] slave_word = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_cs(input logic [31:0] a);
    logic [3:0] v;
    v = 4'hF;
    if (a < 32'd4) v[a[1:0]] = 1'b0;
    return v;
  endfunction

  // Slave: presents bit 15 when the transfer starts, next bit after every SCLK fall.
  initial begin : slave
    logic [15:0] cur;
    int          idx;
    logic        p_busy, p_sclk;
    miso = 1'b0; cur = 16'h0000; idx = 0; p_busy = 1'b0; p_sclk = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.busy && !p_busy) begin
        cur = slave_word; idx = 15; miso = cur[15];
      end else if (bus.busy && p_sclk && !sclk && idx > 0) begin
        idx--; miso = cur[idx];
      end
      p_busy = bus.busy; p_sclk = sclk;
    end
  end

  // Monitor: collects per-transfer observations and checks them at rx_valid.
  initial begin : monitor
    int          busy_cnt, rise_cnt, first_rise;
    logic [15:0] mosi_cap;
    logic        p_sclk;
    bit          cs_bad;
    exp_t        e;
    busy_cnt = 0; rise_cnt = 0; first_rise = 0; mosi_cap = 16'h0000; p_sclk = 1'b0; cs_bad = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.busy) begin
        busy_cnt++;
        if (exp_q.size() == 0 || cs_n !== exp_q[0].cs) cs_bad = 1'b1;
        if (!p_sclk && sclk) begin
          rise_cnt++;
          if (rise_cnt == 1) first_rise = busy_cnt;
          mosi_cap = {mosi_cap[14:0], mosi};
        end
      end
      if (bus.rx_valid === 1'b1) begin
        rx_pulses++;
        chk("sb_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (e.chk_rx) chk("rx_data", bus.rx_data, e.rx);
          chk("mosi_word", mosi_cap, e.tx);
          chk("busy_len", busy_cnt, e.len);
          chk("sclk_rises", rise_cnt, 16);
          chk("first_rise", first_rise, e.len / 17 + 1);
          chk("cs_during_busy", cs_bad, 0);
        end
      end
      if (!bus.busy) begin
        busy_cnt = 0; rise_cnt = 0; first_rise = 0; mosi_cap = 16'h0000; cs_bad = 1'b0;
      end
      p_sclk = sclk;
    end
  end

  task automatic start(input logic [31:0] cd, input logic [31:0] a, input logic [15:0] tx,
                       input logic [15:0] rxw, input bit chk_rx, input int div, input bit keep_en);
    exp_t e;
    e.tx = tx; e.rx = rxw; e.chk_rx = chk_rx; e.cs = exp_cs(a); e.len = 34 * div;
    exp_q.push_back(e);
    slave_word = rxw;
    bus.clk_div = cd; bus.addr = a; bus.tx_data = tx; bus.enable = 1'b1;
    @(posedge clk); #1;
    if (!keep_en) bus.enable = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
    chk("cs_after_accept", cs_n, exp_cs(a));
    chk("mosi_bit15", mosi, tx[15]);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && bus.busy; i++) begin
      @(posedge clk); #1;
    end
    chk("busy_drop_in_time", bus.busy, 0);
    chk("rx_valid_at_drop", bus.rx_valid, 1);
    chk("cs_released", cs_n, 4'hF);
    chk("mosi_idle", mosi, 0);
  endtask

  initial begin : stimulus
    bus.enable = 1'b0; bus.clk_div = 32'd0; bus.addr = 32'd0; bus.tx_data = 16'h0000;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_cs_n", cs_n, 4'hF);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_rx_data", bus.rx_data, 16'h0000);
    chk("rst_rx_valid", bus.rx_valid, 0);

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_busy", bus.busy, 0);
      chk("idle_cs_n", cs_n, 4'hF);
      chk("idle_sclk", sclk, 0);
      chk("idle_rx_valid", bus.rx_valid, 0);
    end

    // Basic transfer, div=3
    start(32'd3, 32'd2, 16'hA55A, 16'h3C96, 1'b1, 3, 1'b0);
    wait_idle(120);
    chk("basic_rx_data", bus.rx_data, 16'h3C96);
    @(posedge clk); #1;
    chk("rx_valid_one_cycle", bus.rx_valid, 0);
    chk("rx_data_held", bus.rx_data, 16'h3C96);

    // clk_div=0 behaves as div=1
    start(32'd0, 32'd0, 16'h5A3C, 16'h0000, 1'b0, 1, 1'b0);
    wait_idle(50);

    // Saturating divider
    start(32'h0001_0000, 32'd1, 16'hC3A5, 16'h5AA5, 1'b1, 255, 1'b0);
    wait_idle(34 * 255 + 20);

    // Enable held high: exactly two back-to-back transfers
    start(32'd3, 32'd0, 16'h0001, 16'h1357, 1'b1, 3, 1'b1);
    @(posedge clk); #1;
    begin
      exp_t e;
      e.tx = 16'h8000; e.rx = 16'hFACE; e.chk_rx = 1'b1; e.cs = 4'b1110; e.len = 102;
      exp_q.push_back(e);
    end
    bus.tx_data = 16'h8000;
    slave_word  = 16'hFACE;
    wait_idle(120);
    @(posedge clk); #1;
    chk("b2b_second_busy", bus.busy, 1);
    chk("b2b_second_mosi", mosi, 1);
    bus.enable = 1'b0;
    wait_idle(120);
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_no_third", bus.busy, 0);

    // Out-of-range chip select
    start(32'd3, 32'd7, 16'h0F0F, 16'h9669, 1'b1, 3, 1'b0);
    wait_idle(120);

    // Reset after 10 SCLK edges
    start(32'd3, 32'd3, 16'hFFFF, 16'hAAAA, 1'b1, 3, 1'b0);
    repeat (32) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_cs_n", cs_n, 4'hF);
    chk("midrst_sclk", sclk, 0);
    chk("midrst_rx_valid", bus.rx_valid, 0);
    chk("midrst_rx_data", bus.rx_data, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_valid", bus.rx_valid, 0);
    start(32'd3, 32'd1, 16'h1234, 16'hBEEF, 1'b1, 3, 1'b0);
    wait_idle(120);
    chk("post_rst_rx_data", bus.rx_data, 16'hBEEF);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    chk("rx_pulse_total", rx_pulses, 7);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
